// File: rtl/spi_calc_unit.sv
`default_nettype none
// ============================================================================
// spi_calc_unit : iterative 8-bit saturating multiplier / optional divider fed by SPI rx
// Build option: define CALC_DIV_EN to compile in the restoring divider.   Rev 1.0
// ============================================================================
module spi_calc_unit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_x,
    input  logic [7:0] rx_y,
    input  logic       rx_valid,
    input  logic       op_div,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       done,
    output logic       ovf,
    output logic       dz,
    output logic       overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic              sync_prev;
    logic              start;
    logic [2:0]        iter_cnt;
    logic [15:0]       acc;
    logic [15:0]       mcand;
    logic [7:0]        opb;
    logic [15:0]       acc_step;
    logic              last_iter;
    logic [7:0]        res_data;
    logic              res_ovf;
    logic              res_dz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff   <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync_ff   <= {sync_ff[SYNC_STAGES-2:0], rx_valid};
            sync_prev <= sync_ff[SYNC_STAGES-1];
        end
    end

    assign start   = sync_ff[SYNC_STAGES-1] & ~sync_prev;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign overrun = start & busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = LOAD;
            LOAD: state_next = ITER;
            ITER: if (iter_cnt == 3'd7) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign last_iter = (state == ITER) && (iter_cnt == 3'd7);
    assign acc_step  = acc + (opb[0] ? mcand : 16'd0);

`ifdef CALC_DIV_EN
    logic       op_div_r;
    logic [7:0] divisor;
    logic [7:0] rem;
    logic [8:0] rem_shift;
    logic [7:0] rem_diff;
    logic       q_bit;

    // opb doubles as dividend (consumed from the MSB) and quotient (filled from the LSB)
    assign rem_shift = {rem, opb[7]};
    assign q_bit     = (rem_shift >= {1'b0, divisor});
    assign rem_diff  = rem_shift[7:0] - divisor;
`else
    logic unused_op_div;
    assign unused_op_div = op_div;
`endif

    always_comb begin
        res_ovf  = |acc_step[15:8];
        res_data = res_ovf ? 8'hFF : acc_step[7:0];
        res_dz   = 1'b0;
`ifdef CALC_DIV_EN
        if (op_div_r) begin
            res_ovf  = 1'b0;
            res_dz   = (divisor == 8'd0);
            res_data = res_dz ? 8'hFF : {opb[6:0], q_bit};
        end
`endif
    end

    // Results are registered on the ITER->DONE edge so they appear together with done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iter_cnt <= 3'd0;
            acc      <= 16'd0;
            mcand    <= 16'd0;
            opb      <= 8'd0;
            tx_data  <= 8'd0;
            ovf      <= 1'b0;
            dz       <= 1'b0;
`ifdef CALC_DIV_EN
            op_div_r <= 1'b0;
            divisor  <= 8'd0;
            rem      <= 8'd0;
`endif
        end else begin
            if (state == LOAD) begin
                iter_cnt <= 3'd0;
                acc      <= 16'd0;
                mcand    <= {8'd0, rx_x};
`ifdef CALC_DIV_EN
                op_div_r <= op_div;
                divisor  <= rx_y;
                rem      <= 8'd0;
                opb      <= op_div ? rx_x : rx_y;
`else
                opb      <= rx_y;
`endif
            end else if (state == ITER) begin
                iter_cnt <= iter_cnt + 3'd1;
`ifdef CALC_DIV_EN
                if (op_div_r) begin
                    opb <= {opb[6:0], q_bit};
                    rem <= q_bit ? rem_diff : rem_shift[7:0];
                end else
`endif
                begin
                    acc   <= acc_step;
                    mcand <= {mcand[14:0], 1'b0};
                    opb   <= {1'b0, opb[7:1]};
                end
                if (last_iter) begin
                    tx_data <= res_data;
                    ovf     <= res_ovf;
                    dz      <= res_dz;
                end
            end
        end
    end

endmodule
`default_nettype wire
